time_counter: RTL
=================

# time_counter

Timekeeping datapath for the digital clock. Holds current hour, minute and second as packed BCD and advances each field on single-cycle enable strobes that `control` produces from its mode muxes. Emits one-cycle rollover carries (`sbit` from seconds, `mbit` from minutes) that `control` routes back as the next field's increment in run mode. Fully synchronous to the single system clock; no derived clocks.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `clr`  input  1  synchronous clear of all fields, driven by `control.rst` path
- `tick_s`  input  1  one-cycle strobe; advance seconds
- `inc_m`  input  1  one-cycle strobe; advance minutes (carry in run mode, button in set mode)
- `inc_h`  input  1  one-cycle strobe; advance hours
- `hour`  output  8  packed BCD hour
- `minute`  output  8  packed BCD minute, 00..59
- `second`  output  8  packed BCD second, 00..59
- `sbit`  output  1  one-cycle pulse, seconds wrapped 59->00
- `mbit`  output  1  one-cycle pulse, minutes wrapped 59->00
- `pm`  output  1  afternoon flag (12-hour build only, else constant 0)

## Operation
- Three independent BCD counters. No internal ripple between fields; carry chaining is external through `control`.
- BCD increment: if the low nibble is 9, clear it and increment the high nibble; otherwise increment the low nibble.
- Seconds: on `tick_s`, advance. At 8'h59, wrap to 8'h00 and register `sbit`=1 for exactly one cycle.
- Minutes: on `inc_m`, advance. At 8'h59, wrap to 8'h00 and register `mbit`=1 for exactly one cycle. This applies regardless of strobe source, including set mode.
- Hours, 24-hour build: on `inc_h`, advance 00..23. At 8'h23, wrap to 8'h00. No carry out.
- Only the 8'h59 and 8'h23 states wrap; no other values are reachable after reset.
- Strobes held high for N cycles advance the field N times.
- Priority, highest first:
  - `reset` low: fields and flags take their reset values immediately, independent of `clk`.
  - `clr` high: all fields take their reset values, `sbit`=`mbit`=0, and all strobes that cycle are ignored.
  - Otherwise each field updates independently. Any combination of `tick_s`, `inc_m` and `inc_h` in one cycle updates all addressed fields.
- Reset values:
  - `second`=8'h00, `minute`=8'h00, `sbit`=0, `mbit`=0.
  - `hour`=8'h00 and `pm`=0 in the 24-hour build; `hour`=8'h12 and `pm`=0 in the 12-hour build.

## Timing
- All outputs are registered. A field's new value is visible the cycle after the strobe is sampled high.
- `sbit` and `mbit` assert in the same cycle the wrapped value 8'h00 becomes visible, and deassert one cycle later.
- Run-mode loop: `sbit` passes combinationally through `control` to `inc_m`, so the minute updates one cycle after the second shows 00. `mbit` passes to `inc_h`, so the hour updates one cycle after the minute shows 00.
- Full rollover 23:59:59 -> 00:00:00 completes 3 cycles after the `tick_s` edge.
- Reset assertion mid-rollover discards any pending carry. Release is synchronized by the surrounding design; this block adds no release synchronizer.

## Configuration
- `TIME_COUNTER_12H_EN` defined:
  - Hour sequence is 12, 01, 02, ..., 11, 12 (packed BCD). 8'h12 advances to 8'h01.
  - `pm` toggles on the 8'h11 -> 8'h12 transition.
  - Reset and `clr` give `hour`=8'h12, `pm`=0.
- Undefined:
  - 24-hour counting as described under Operation.
  - `pm` tied to 0.

## Test plan
- Assert `reset` low mid-count, with no clock edge -> all outputs immediately at reset values; `sbit`=`mbit`=0.
- Apply 60 `tick_s` pulses from 00 -> `second` steps 8'h09 -> 8'h10 correctly, ends at 8'h00, and `sbit` is high for exactly one cycle on the wrap.
- Close the run-mode loop (`inc_m`=`sbit`, `inc_h`=`mbit`) at 23:59:59 and apply one `tick_s` -> 00:00:00 three cycles later; `sbit`, then `mbit`, each pulse once.
- In the same cycle assert `clr` together with `tick_s`, `inc_m` and `inc_h` at 12:34:56 -> next cycle shows 00:00:00, no carries.
- Hold `inc_m` high for 3 cycles starting at minute 8'h58 -> minute goes 59, 00, 01; `mbit` pulses once.
- 12-hour build: step `inc_h` from reset through 13 strobes -> sequence 12, 01..11, 12, 01; `pm` rises at the 11->12 step and is 1 at the end.

Source files
------------

// File: rtl/time_counter.sv
// ----------------------------------------------------------------------------
// time_counter
//
// Timekeeping datapath for the digital clock. Holds hour, minute and second
// as packed BCD and advances each field on single-cycle enable strobes.
// Seconds and minutes emit registered one-cycle wrap carries (sbit, mbit);
// chaining between fields is done externally by the control block.
//
// Build option:
//   TIME_COUNTER_12H_EN  defined   -> 12-hour hours (12,01..11), pm flag
//                        undefined -> 24-hour hours (00..23), pm tied to 0
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   clr     in   synchronous clear of all fields; overrides the strobes
//   tick_s  in   advance seconds
//   inc_m   in   advance minutes
//   inc_h   in   advance hours
//   hour    out  [7:0] packed BCD hour
//   minute  out  [7:0] packed BCD minute 00..59
//   second  out  [7:0] packed BCD second 00..59
//   sbit    out  one-cycle pulse when seconds wrap 59->00
//   mbit    out  one-cycle pulse when minutes wrap 59->00
//   pm      out  afternoon flag (12-hour build only)
// ----------------------------------------------------------------------------
module time_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       tick_s,
    input  logic       inc_m,
    input  logic       inc_h,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       sbit,
    output logic       mbit,
    output logic       pm
);

`ifdef TIME_COUNTER_12H_EN
    localparam logic [7:0] HOUR_RST = 8'h12;
`else
    localparam logic [7:0] HOUR_RST = 8'h00;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Seconds and carry; sbit is registered so it lines up with 00 on the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            second <= '0;
            sbit   <= 1'b0;
        end else if (clr) begin
            second <= '0;
            sbit   <= 1'b0;
        end else begin
            sbit <= 1'b0;
            if (tick_s) begin
                if (second == 8'h59) begin
                    second <= '0;
                    sbit   <= 1'b1;
                end else begin
                    second <= bcd_inc(second);
                end
            end
        end
    end

    // Minutes and carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            minute <= '0;
            mbit   <= 1'b0;
        end else if (clr) begin
            minute <= '0;
            mbit   <= 1'b0;
        end else begin
            mbit <= 1'b0;
            if (inc_m) begin
                if (minute == 8'h59) begin
                    minute <= '0;
                    mbit   <= 1'b1;
                end else begin
                    minute <= bcd_inc(minute);
                end
            end
        end
    end

`ifdef TIME_COUNTER_12H_EN
    // 12-hour sequence 12,01..11,12; pm flips when 11 advances to 12.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour <= HOUR_RST;
            pm   <= 1'b0;
        end else if (clr) begin
            hour <= HOUR_RST;
            pm   <= 1'b0;
        end else if (inc_h) begin
            if (hour == 8'h12) begin
                hour <= 8'h01;
            end else begin
                hour <= bcd_inc(hour);
                if (hour == 8'h11)
                    pm <= ~pm;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour <= HOUR_RST;
        end else if (clr) begin
            hour <= HOUR_RST;
        end else if (inc_h) begin
            if (hour == 8'h23)
                hour <= '0;
            else
                hour <= bcd_inc(hour);
        end
    end

    assign pm = 1'b0;
`endif

endmodule
